// File: rtl/pc_sequencer.sv
// Word-addressed PC controller sharing one 30-bit A+B+Cin adder between increment and branch target.
// Optional PC_SEQ_WRAP_TRAP_EN: increment past the top word reloads RESET_PC and pulses TRAP.
module pc_sequencer #(
   parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        STALL,
   input  logic        JUMP,
   input  logic [25:0] JUMP_TARGET,
   input  logic        BRANCH,
   input  logic [29:0] BR_OFFSET,
   output logic [29:0] PC,
   output logic        PC_VALID,
   output logic        BUSY
`ifdef PC_SEQ_WRAP_TRAP_EN
   ,output logic       TRAP
`endif
);

   typedef enum logic [1:0] {S_RST, S_RUN, S_BCALC} state_t;

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [29:0] base_q, base_d;
   logic [29:0] off_q, off_d;
   logic [29:0] add_a, add_b, add_sum;
   logic        add_cin;
   logic        trap_d;
`ifdef PC_SEQ_WRAP_TRAP_EN
   logic        trap_q;
`endif

   // Single shared adder; carry-out is dropped so all arithmetic wraps modulo 2^30.
   assign add_sum = add_a + add_b + {29'd0, add_cin};

   always_comb begin
      add_a   = pc_q;
      add_b   = '0;
      add_cin = 1'b1;
      state_d = state_q;
      pc_d    = pc_q;
      base_d  = base_q;
      off_d   = off_q;
      trap_d  = 1'b0;
      if (state_q == S_BCALC) begin
         add_a   = base_q;
         add_b   = off_q;
         add_cin = 1'b0;
      end
      case (state_q)
         S_RST: state_d = S_RUN;
         S_RUN: begin
            if (STALL) begin
               pc_d = pc_q;
            end else if (JUMP) begin
               pc_d = {add_sum[29:26], JUMP_TARGET};
            end else if (BRANCH) begin
               base_d  = add_sum;
               off_d   = BR_OFFSET;
               state_d = S_BCALC;
            end else begin
`ifdef PC_SEQ_WRAP_TRAP_EN
               if (pc_q == '1) begin
                  pc_d   = RESET_PC;
                  trap_d = 1'b1;
               end else begin
                  pc_d = add_sum;
               end
`else
               pc_d = add_sum;
`endif
            end
         end
         S_BCALC: begin
            pc_d    = add_sum;
            state_d = S_RUN;
         end
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         base_q  <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         base_q  <= base_d;
         off_q   <= off_d;
      end
   end

`ifdef PC_SEQ_WRAP_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) trap_q <= 1'b0;
      else       trap_q <= trap_d;
   end
   assign TRAP = trap_q;
`else
   logic unused_trap;
   assign unused_trap = trap_d;
`endif

   assign PC       = pc_q;
   assign PC_VALID = (state_q == S_RUN);
   assign BUSY     = (state_q == S_BCALC);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_PC = 30'h100.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, jump, branch;
   logic [25:0] jump_target;
   logic [29:0] br_offset;
   logic [29:0] pc;
   logic        pc_valid, busy;
   logic        trap;
   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(30'h100)) dut (
      .clk        (clk),
      .reset      (reset),
      .STALL      (stall),
      .JUMP       (jump),
      .JUMP_TARGET(jump_target),
      .BRANCH     (branch),
      .BR_OFFSET  (br_offset),
      .PC         (pc),
      .PC_VALID   (pc_valid),
      .BUSY       (busy)
`ifdef PC_SEQ_WRAP_TRAP_EN
      ,.TRAP      (trap)
`endif
   );

`ifndef PC_SEQ_WRAP_TRAP_EN
   assign trap = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [29:0] epc, input logic ev,
                              input logic eb, input logic et);
      check_eq({tag, ".pc"},    {2'b0, pc},       {2'b0, epc});
      check_eq({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, ev});
      check_eq({tag, ".busy"},  {31'b0, busy},     {31'b0, eb});
      check_eq({tag, ".trap"},  {31'b0, trap},     {31'b0, et});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; jump = 1'b0; branch = 1'b0;
      jump_target = '0; br_offset = '0;
      repeat (3) step();
      check_state("reset", 30'h100, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #2;
      check_state("rst_hold", 30'h100, 1'b0, 1'b0, 1'b0);
      step(); check_state("run0", 30'h100, 1'b1, 1'b0, 1'b0);
      step(); check_state("run1", 30'h101, 1'b1, 1'b0, 1'b0);
      step(); check_state("run2", 30'h102, 1'b1, 1'b0, 1'b0);

      // 0x103 + 0xFD = 0x200
      branch = 1'b1; br_offset = 30'h0FD;
      step(); check_state("br200_busy", 30'h102, 1'b0, 1'b1, 1'b0);
      branch = 1'b0;
      step(); check_state("br200_tgt", 30'h200, 1'b1, 1'b0, 1'b0);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); check_state("stall", 30'h200, 1'b1, 1'b0, 1'b0);
      end
      branch = 1'b1; br_offset = 30'h10;
      step(); check_state("stall_over_br", 30'h200, 1'b1, 1'b0, 1'b0);
      stall = 1'b0; branch = 1'b0;

      branch = 1'b1; br_offset = 30'h3FFF_FFFC;
      step(); check_state("brneg_busy", 30'h200, 1'b0, 1'b1, 1'b0);
      branch = 1'b0; jump = 1'b1; jump_target = 26'h0000_055;
      step(); check_state("brneg_tgt", 30'h1FD, 1'b1, 1'b0, 1'b0);
      jump = 1'b0;

      // 0x1FE + 0x2FFFFE12 = 0x30000010
      branch = 1'b1; br_offset = 30'h2FFF_FE12;
      step(); check_state("brhi_busy", 30'h1FD, 1'b0, 1'b1, 1'b0);
      branch = 1'b0;
      step(); check_state("brhi_tgt", 30'h3000_0010, 1'b1, 1'b0, 1'b0);

      jump = 1'b1; branch = 1'b1; jump_target = 26'h0AB_CDEF; br_offset = 30'h40;
      step(); check_state("jump", 30'h30AB_CDEF, 1'b1, 1'b0, 1'b0);
      jump = 1'b0; branch = 1'b0;

      // 0x30ABCDF0 + 0x0F54320F = 0x3FFFFFFF
      branch = 1'b1; br_offset = 30'h0F54_320F;
      step(); check_state("brtop_busy", 30'h30AB_CDEF, 1'b0, 1'b1, 1'b0);
      branch = 1'b0;
      step(); check_state("brtop_tgt", 30'h3FFF_FFFF, 1'b1, 1'b0, 1'b0);

`ifdef PC_SEQ_WRAP_TRAP_EN
      step(); check_state("wrap_trap", 30'h100, 1'b1, 1'b0, 1'b1);
      step(); check_state("after_trap", 30'h101, 1'b1, 1'b0, 1'b0);
`else
      step(); check_state("wrap", 30'h0, 1'b1, 1'b0, 1'b0);
      step(); check_state("after_wrap", 30'h1, 1'b1, 1'b0, 1'b0);
`endif

      // offset -1 from base PC+1 lands back on PC
      branch = 1'b1; br_offset = 30'h3FFF_FFFF;
      step(); check_eq("brm1_busy", {31'b0, busy}, 32'd1);
      branch = 1'b0;
`ifdef PC_SEQ_WRAP_TRAP_EN
      step(); check_state("brm1_tgt", 30'h101, 1'b1, 1'b0, 1'b0);
`else
      step(); check_state("brm1_tgt", 30'h1, 1'b1, 1'b0, 1'b0);
`endif

      branch = 1'b1; br_offset = 30'h50;
      step(); check_eq("brrst_busy", {31'b0, busy}, 32'd1);
      branch = 1'b0;
      #2 reset = 1'b1;
      #1 check_state("async_rst", 30'h100, 1'b0, 1'b0, 1'b0);
      step(); check_state("rst_held", 30'h100, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(); check_state("rst_run0", 30'h100, 1'b1, 1'b0, 1'b0);
      step(); check_state("rst_run1", 30'h101, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Word-addressed program-counter controller for the single-cycle MIPS datapath. It owns the 30-bit PC register and time-shares one 30-bit adder, configured as A + B + Cin, between sequential increment (PC + 1) and branch-target calculation (PC + 1 + offset). It sits between the control unit (stall/branch/jump requests) and the instruction memory address port (PC[29:0] = byte address [31:2]).

## Interface
- RESET_PC, 30'h0000_0000, word address loaded on reset.

- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- STALL  in  1  hold PC this cycle
- JUMP  in  1  jump request; target = {PC_plus1[29:26], JUMP_TARGET}
- JUMP_TARGET  in  26  instruction index field
- BRANCH  in  1  taken-branch request
- BR_OFFSET  in  30  sign-extended word offset
- PC  out  30  current instruction word address
- PC_VALID  out  1  PC holds a fetchable address this cycle
- BUSY  out  1  branch target being computed; requests ignored
- TRAP  out  1  present only with PC_SEQ_WRAP_TRAP_EN (see Configuration)

## Operation
- Shared adder: one 30-bit A + B + Cin instance. In RUN: A = PC, B = 0, Cin = 1. In BCALC: A = base_q, B = off_q, Cin = 0. Arithmetic is modulo 2^30; carry-out is discarded.
- States: RST, RUN, BCALC.
- RST: entered asynchronously on reset. Always advances to RUN on the next clock edge; PC is unchanged.
- RUN (priority STALL > JUMP > BRANCH > increment):
  - STALL: PC holds.
  - JUMP: PC <= {PC_plus1[29:26], JUMP_TARGET}.
  - BRANCH: base_q <= PC + 1, off_q <= BR_OFFSET, state -> BCALC; PC holds.
  - none: PC <= PC + 1.
- BCALC: PC <= base_q + off_q, state -> RUN. STALL, JUMP and BRANCH are ignored (not queued).
- Wrap: PC = 30'h3FFF_FFFF with increment -> 30'h0000_0000.
- Branch offset is signed: 30'h3FFF_FFFF (-1) from base B yields B - 1.
- Reset mid-BCALC: pending branch discarded; PC = RESET_PC.

## Timing
- Reset values: PC = RESET_PC, PC_VALID = 0, BUSY = 0, TRAP = 0, state = RST, base_q = 0, off_q = 0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- PC_VALID = (state == RUN). BUSY = (state == BCALC).
- Increment and jump: new PC visible 1 cycle after the request edge.
- Branch: 2-cycle latency. PC holds, PC_VALID = 0 and BUSY = 1 for one cycle, then the target appears with PC_VALID = 1.
- After reset deassertion: first edge RST -> RUN; RESET_PC is valid for fetch on that cycle.

## Configuration
- PC_SEQ_WRAP_TRAP_EN defined:
  - TRAP port exists.
  - A sequential increment from 30'h3FFF_FFFF loads RESET_PC instead of wrapping.
  - TRAP is high for exactly one cycle, coincident with that PC update.
  - Jump and branch arithmetic still wraps silently.
- Macro undefined: TRAP port absent; the increment wraps to 0.

## Test plan
- Reset with RESET_PC = 30'h100, release, no requests -> PC = 100, 100 (PC_VALID rises), 101, 102; PC_VALID = 0 only while in RST.
- At PC = 30'h200, STALL held 3 cycles, then BRANCH with BR_OFFSET = 30'h10 and STALL also high on the BRANCH cycle -> PC holds at 200 for 3 cycles; the branch is not taken (STALL wins).
- At PC = 30'h200, BRANCH with BR_OFFSET = 30'h3FFF_FFFC (-4) -> BUSY = 1 and PC = 200 for one cycle, then PC = 30'h1FD; a JUMP asserted during BCALC is ignored.
- At PC = 30'h3000_0010, JUMP with JUMP_TARGET = 26'h0ABCDEF (JUMP and BRANCH both high) -> PC = 30'h30AB_CDEF; no BCALC entered.
- At PC = 30'h3FFF_FFFF, increment -> PC = 0 (macro off); PC = RESET_PC and a one-cycle TRAP (macro on).
- Assert reset asynchronously during BCALC -> PC = RESET_PC and BUSY = 0 immediately, without waiting for a clock edge; the branch target never appears.
